// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared definitions for the stepped sequence blocks: FSM state
//            encodings and active-low 7-segment glyphs. Bit 7 of each glyph
//            is the decimal point and is held off (1).
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_SEND = 3'b001;
    localparam logic [2:0] ST_GAP  = 3'b011;
    localparam logic [2:0] ST_DONE = 3'b010;

    localparam logic [7:0] SEG_0     = 8'b1100_0000;
    localparam logic [7:0] SEG_1     = 8'b1111_1001;
    localparam logic [7:0] SEG_2     = 8'b1010_0100;
    localparam logic [7:0] SEG_3     = 8'b1011_0000;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b1001_0010;
    localparam logic [7:0] SEG_6     = 8'b1000_0010;
    localparam logic [7:0] SEG_7     = 8'b1111_1000;
    localparam logic [7:0] SEG_8     = 8'b1000_0000;
    localparam logic [7:0] SEG_9     = 8'b1001_1000;
    localparam logic [7:0] SEG_DASH  = 8'b1011_1111;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_glyph = SEG_0;
            4'd1:    seg_glyph = SEG_1;
            4'd2:    seg_glyph = SEG_2;
            4'd3:    seg_glyph = SEG_3;
            4'd4:    seg_glyph = SEG_4;
            4'd5:    seg_glyph = SEG_5;
            4'd6:    seg_glyph = SEG_6;
            4'd7:    seg_glyph = SEG_7;
            4'd8:    seg_glyph = SEG_8;
            4'd9:    seg_glyph = SEG_9;
            default: seg_glyph = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_step_sync.sv
`default_nettype none
// ============================================================================
// Module   : key_step_sync
// Purpose  : Turns an asynchronous active-low pushbutton into a one-clock
//            step strobe on the press (1->0) edge. Release generates nothing.
// Ports    : clock    - system clock
//            reset    - asynchronous active-high reset (flops reset to 1)
//            key_n_i  - raw active-low key
//            step_o   - one-clock strobe, 2-3 clocks after the press
// Revision : 1.0 - initial release
// ============================================================================
module key_step_sync (
    input  logic clock,
    input  logic reset,
    input  logic key_n_i,
    output logic step_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic level_q;

    // sync1/sync2 form the metastability synchronizer. level_q only follows
    // the synchronized key once two consecutive samples agree, so a bounce
    // lasting a single clock (either polarity) never produces a new edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (sync2_q == sync3_q) begin
                level_q <= sync2_q;
            end
        end
    end

    assign step_o = level_q & ~sync2_q & ~sync3_q;

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Stepped serial pattern transmitter. Sends a 1..PAT_W-bit pattern
//            MSB first, one bit per key1 press, with repeated frames separated
//            by an idle gap step, abort, and 7-segment status digits.
// Ports    : clock, reset (async, active-high), key1 (active-low step key),
//            start, abort, pattern, length, repeats (latched on start);
//            serial_out, bit_valid, busy, done, frames_sent, current_state,
//            DISP0 (glyph of serial_out), DISP1 (frames_sent digit or dash)
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key1,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [3:0]       repeats,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent,
    output logic [2:0]       current_state,
    output logic [7:0]       DISP0,
    output logic [7:0]       DISP1
);

    localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);

    logic [2:0]       state_q,   state_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [PAT_W-1:0] shreg_q,   shreg_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [3:0]       reps_q,    reps_d;
    logic [CNT_W-1:0] frames_q,  frames_d;

    logic             w_step;
    logic [LEN_W-1:0] w_eff_len;

    key_step_sync u_key_step_sync (
        .clock   (clock),
        .reset   (reset),
        .key_n_i (key1),
        .step_o  (w_step)
    );

    assign w_eff_len = ((length == '0) || (length > PAT_LEN)) ? PAT_LEN : length;

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            shreg_q   <= '1;
            len_q     <= PAT_LEN;
            bit_idx_q <= '0;
            reps_q    <= 4'd1;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            len_q     <= len_d;
            bit_idx_q <= bit_idx_d;
            reps_q    <= reps_d;
            frames_q  <= frames_d;
        end
    end

    // Next state. The shift register's MSB is always the bit on the line
    // during SEND, so advancing a bit is a left shift.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        len_d     = len_q;
        bit_idx_d = bit_idx_q;
        reps_d    = reps_q;
        frames_d  = frames_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    pat_d     = pattern;
                    shreg_d   = pattern;
                    len_d     = w_eff_len;
                    bit_idx_d = w_eff_len - LEN_W'(1);
                    reps_d    = (repeats == 4'd0) ? 4'd1 : repeats;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_step) begin
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - LEN_W'(1);
                        shreg_d   = {shreg_q[PAT_W-2:0], 1'b1};
                    end else begin
                        frames_d = frames_q + CNT_W'(1);
                        if (reps_q > 4'd1) begin
                            reps_d  = reps_q - 4'd1;
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_step) begin
                    shreg_d   = pat_q;
                    bit_idx_d = len_q - LEN_W'(1);
                    state_d   = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs, decoded from registered state only
    always_comb begin
        serial_out = 1'b1;
        bit_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        if (state_q == ST_SEND) begin
            serial_out = shreg_q[PAT_W-1];
            bit_valid  = 1'b1;
        end
        DISP0 = serial_out ? SEG_1 : SEG_0;
        DISP1 = (frames_q < CNT_W'(10)) ? seg_glyph(4'(frames_q)) : SEG_DASH;
    end

    assign frames_sent   = frames_q;
    assign current_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx. Expected line values are
//            built from the frame rules as a list of (bit, valid) steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             key1;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [3:0]       repeats;
    logic             serial_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;
    logic [2:0]       current_state;
    logic [7:0]       DISP0;
    logic [7:0]       DISP1;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int frames_model = 0;

    seq_pattern_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .key1          (key1),
        .start         (start),
        .abort         (abort),
        .pattern       (pattern),
        .length        (length),
        .repeats       (repeats),
        .serial_out    (serial_out),
        .bit_valid     (bit_valid),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent),
        .current_state (current_state),
        .DISP0         (DISP0),
        .DISP1         (DISP1)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] exp_disp1(input int n);
        logic [7:0] g;
        case (n)
            0: g = 8'b11000000;  1: g = 8'b11111001;  2: g = 8'b10100100;
            3: g = 8'b10110000;  4: g = 8'b10011001;  5: g = 8'b10010010;
            6: g = 8'b10000010;  7: g = 8'b11111000;  8: g = 8'b10000000;
            9: g = 8'b10011000;  default: g = 8'b10111111;
        endcase
        return g;
    endfunction

    task automatic press();
        @(negedge clock); key1 = 1'b0;
        repeat (6) @(negedge clock);
        key1 = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic pulse_start(input bit with_abort);
        @(negedge clock); start = 1'b1; abort = with_abort;
        @(negedge clock); start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({serial_out, bit_valid, busy, done, current_state} !== 7'b1000_000) begin
            errors++;
            $display("FAIL reset_ctrl: got s=%b v=%b b=%b d=%b st=%b want 1 0 0 0 000",
                     serial_out, bit_valid, busy, done, current_state);
        end
        checks++;
        if (frames_sent !== '0 || DISP0 !== 8'b11111001 || DISP1 !== 8'b11000000) begin
            errors++;
            $display("FAIL reset_disp: got frames=%0d D0=%b D1=%b want 0 11111001 11000000",
                     frames_sent, DISP0, DISP1);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        frames_model = 0;
        repeat (2) @(negedge clock);
    endtask

    // Builds the expected (bit, valid) list for one transfer and walks it one
    // key press at a time. Input buses are scrambled after start to show that
    // the transfer uses only the latched values.
    task automatic run_frame(input logic [7:0] pat, input logic [3:0] len,
                             input logic [3:0] reps, input bit mid_start, input string name);
        int eff_len;
        int nfr;
        int d0;
        bit exp_s[$];
        bit exp_v[$];
        eff_len = (len == 0 || len > PAT_W) ? PAT_W : int'(len);
        nfr     = (reps == 0) ? 1 : int'(reps);
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < eff_len; k++) begin
                exp_s.push_back(pat[PAT_W-1-k]);
                exp_v.push_back(1'b1);
            end
            exp_s.push_back(1'b1);
            exp_v.push_back(1'b0);
        end
        d0 = done_cnt;
        pattern = pat; length = len; repeats = reps;
        pulse_start(1'b0);
        pattern = 8'($urandom); length = 4'($urandom); repeats = 4'($urandom);
        for (int i = 0; i < exp_s.size(); i++) begin
            if (i > 0) press();
            if (mid_start && i == 1 && i < exp_s.size() - 1) pulse_start(1'b0);
            checks++;
            if (serial_out !== exp_s[i] || bit_valid !== exp_v[i] ||
                busy !== (i < exp_s.size() - 1)) begin
                errors++;
                $display("FAIL %s step %0d: got s=%b v=%b b=%b want s=%b v=%b b=%b", name, i,
                         serial_out, bit_valid, busy, exp_s[i], exp_v[i], i < exp_s.size() - 1);
            end
        end
        frames_model = (frames_model + nfr) % (1 << CNT_W);
        checks++;
        if (done_cnt - d0 != 1 || current_state !== 3'b000) begin
            errors++;
            $display("FAIL %s end: got done_pulses=%0d st=%b want 1 000", name,
                     done_cnt - d0, current_state);
        end
        checks++;
        if (frames_sent !== CNT_W'(frames_model) || DISP1 !== exp_disp1(frames_model) ||
            DISP0 !== 8'b11111001) begin
            errors++;
            $display("FAIL %s count: got frames=%0d D1=%b D0=%b want %0d %b 11111001", name,
                     frames_sent, DISP1, DISP0, frames_model, exp_disp1(frames_model));
        end
    endtask

    task automatic test_directed();
        run_frame(8'b0111_0000, 4'd4, 4'd1, 1'b0, "len4");
        run_frame(8'b1000_0000, 4'd2, 4'd3, 1'b0, "rep3");
        run_frame(8'hA5,        4'd0, 4'd0, 1'b0, "len0");
        run_frame(8'h3C,        4'd12, 4'd1, 1'b1, "len12_midstart");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_frame(8'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), n[0], "rand");
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        pattern = 8'b1010_0000; length = 4'd4; repeats = 4'd2;
        pulse_start(1'b0);
        press();
        press();
        checks++;
        if (serial_out !== 1'b1 || bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got s=%b v=%b want 1 1", serial_out, bit_valid);
        end
        @(negedge clock); abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        checks++;
        if (current_state !== 3'b000 || serial_out !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got st=%b s=%b v=%b b=%b want 000 1 0 0",
                     current_state, serial_out, bit_valid, busy);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (done_cnt != d0 || frames_sent !== CNT_W'(frames_model)) begin
            errors++;
            $display("FAIL abort_nodone: got done_pulses=%0d frames=%0d want 0 %0d",
                     done_cnt - d0, frames_sent, frames_model);
        end
        // start and abort together in IDLE: abort wins
        pulse_start(1'b1);
        checks++;
        if (current_state !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort: got st=%b b=%b want 000 0", current_state, busy);
        end
    endtask

    task automatic test_wrap();
        bit saw_dash = 1'b0;
        bit saw_wrap = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (frames_model == 63) saw_wrap = 1'b1;
            if (frames_model >= 10) saw_dash = 1'b1;
            run_frame(8'($urandom), 4'd1, 4'd1, 1'b0, "wrap");
        end
        checks++;
        if (!(saw_wrap && saw_dash)) begin
            errors++;
            $display("FAIL wrap_cover: got wrap=%b dash=%b want 1 1", saw_wrap, saw_dash);
        end
    endtask

    task automatic test_bounce();
        pattern = 8'b0101_0000; length = 4'd4; repeats = 4'd1;
        pulse_start(1'b0);
        // press with a one-clock release bounce in the middle
        @(negedge clock); key1 = 1'b0;
        repeat (4) @(negedge clock); key1 = 1'b1;
        @(negedge clock); key1 = 1'b0;
        repeat (5) @(negedge clock); key1 = 1'b1;
        repeat (6) @(negedge clock);
        checks++;
        if (serial_out !== 1'b1 || bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL bounce_hold: got s=%b v=%b want 1 1", serial_out, bit_valid);
        end
        // lone one-clock low glitch
        @(negedge clock); key1 = 1'b0;
        @(negedge clock); key1 = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if (serial_out !== 1'b1 || bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL bounce_glitch: got s=%b v=%b want 1 1", serial_out, bit_valid);
        end
        @(negedge clock); abort = 1'b1;
        @(negedge clock); abort = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        pattern = 8'b0000_0000; length = 4'd4; repeats = 4'd1;
        pulse_start(1'b0);
        press();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || frames_sent !== '0 ||
            DISP1 !== 8'b11000000 || current_state !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_send: got s=%b b=%b frames=%0d D1=%b st=%b want 1 0 0 11000000 000",
                     serial_out, busy, frames_sent, DISP1, current_state);
        end
        @(negedge clock); reset = 1'b0;
        frames_model = 0;
    endtask

    initial begin
        key1 = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; length = '0; repeats = '0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_bounce();
        test_wrap();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial bit-pattern transmitter. It is the source side of the stepped sequence-detector FSM.
- Drives a programmable 1..PAT_W-bit pattern onto serial_out, MSB first, one bit per step.
- Steps come from the same active-low pushbutton key1 that clocks the detector.
- Advances on key press (falling edge), so the bit is stable before the detector samples on key release.
- Supports repeated frames with an idle gap, abort, and a 7-segment status readout.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of length input (must hold PAT_W)
CNT_W, 6, width of frames_sent counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
key1  in  1  active-low step pushbutton, asynchronous to clock
start  in  1  synchronous start pulse; accepted only in IDLE
abort  in  1  synchronous abort; returns to IDLE
pattern  in  PAT_W  pattern, latched on start; bit PAT_W-1 sent first
length  in  LEN_W  bits per frame; 0 or >PAT_W means PAT_W
repeats  in  4  frames to send; 0 means 1
serial_out  out  1  transmitted bit; idle level 1
bit_valid  out  1  high while serial_out carries a pattern bit (SEND)
busy  out  1  high in SEND, GAP, DONE
done  out  1  one-clock pulse at end of last frame
frames_sent  out  CNT_W  completed frames since reset; wraps
current_state  out  3  FSM state, for debug LEDs
DISP0  out  8  active-low 7-seg glyph of serial_out; bit7 (DP) = 1
DISP1  out  8  active-low 7-seg glyph of frames_sent % 10; dash if frames_sent>=10; bit7 = 1

Behaviour:
Reset values (async, immediate):
- state IDLE; serial_out=1; bit_valid=0; busy=0; done=0; frames_sent=0.
- DISP0=8'b11111001 (glyph "1"); DISP1=8'b11000000 (glyph "0"); step sync flops=1.

step strobe:
- key1 passes a 2-flop synchronizer, then a 1->0 edge detect.
- One-clock strobe, 2-3 clocks after the press; release generates nothing.

States (3'b encodings): IDLE=000, SEND=001, GAP=011, DONE=010.
- IDLE, start=1:
  - latch pattern, eff_len = clamp(length), reps_left = max(repeats,1);
  - bit_idx=eff_len-1; serial_out=pattern[PAT_W-1]; bit_valid=1; next SEND.
  - Frame bit k (k=0..eff_len-1) = pattern[PAT_W-1-k].
- SEND, step:
  - bit_idx>0: bit_idx-1, serial_out = next bit.
  - bit_idx==0: frames_sent+1.
    - reps_left>1: reps_left-1, serial_out=1, bit_valid=0, next GAP.
    - otherwise: serial_out=1, bit_valid=0, next DONE.
- GAP, step: reload bit_idx=eff_len-1, serial_out=first bit, bit_valid=1, next SEND.
- DONE: done=1 for exactly one clock, next IDLE unconditionally.
- abort in SEND/GAP: next clock IDLE, serial_out=1, bit_valid=0, no done, frames_sent unchanged.

Priority and boundary rules:
- Priority: reset > abort > step.
- start outside IDLE is ignored; start and abort together in IDLE: abort wins, stays IDLE.
- Inputs are latched at start; later changes to pattern/length/repeats do not affect the transfer in progress.
- frames_sent wraps from 2^CNT_W-1 to 0.
- Seven-seg codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, dash=0111111.
- Display outputs are combinational from registered state.

Decomposition:
Package seq_pkg holds:
- state encodings IDLE/SEND/GAP/DONE;
- the 7-seg glyph constants (digits 0-9, dash, blank).

One sub-module, key_step_sync: 2-flop synchronizer plus falling-edge strobe, reset to 1s. It is shared with future stepped blocks.

Test Plan:
- Reset asserted mid-SEND -> same clock: serial_out=1, busy=0, frames_sent=0, DISP1=8'b11000000.
- pattern=8'b0111_0000, length=4, repeats=1, 4 key presses -> serial_out 0,1,1,1 with bit_valid=1. Then serial_out=1, done pulse 1 clock, frames_sent=1, DISP1=8'b11111001.
- pattern=8'b1000_0000, length=2, repeats=3, 8 presses -> 1,0,gap(1),1,0,gap(1),1,0. Then done; frames_sent=3.
- length=0, pattern=8'hA5, repeats=0 -> 8 bits 1,0,1,0,0,1,0,1, one frame, done once.
- abort after 2 of 4 bits -> next clock IDLE, serial_out=1, no done, frames_sent unchanged. start pulsed during SEND -> ignored, sequence unaltered.
- 64 single-bit frames -> frames_sent wraps 63->0; DISP1=dash for counts 10..63. Key bounce shorter than 2 clocks -> no extra step.
